// File: rtl/prng_pkg.sv
// prng_pkg: shared LFSR constants, maximal-length Galois masks and next-state function
package prng_pkg;
  localparam logic [15:0] DEF_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'hACE1;
  function automatic logic [31:0] max_taps(input int w);
    case (w)
      4:  return 32'h9;
      5:  return 32'h12;
      6:  return 32'h21;
      7:  return 32'h41;
      8:  return 32'h8E;
      9:  return 32'h108;
      10: return 32'h204;
      11: return 32'h402;
      12: return 32'h829;
      13: return 32'h100D;
      14: return 32'h2015;
      15: return 32'h4001;
      16: return 32'hB400;
      17: return 32'h10004;
      18: return 32'h20040;
      19: return 32'h40023;
      20: return 32'h80004;
      21: return 32'h100002;
      22: return 32'h200001;
      23: return 32'h400010;
      24: return 32'h80000D;
      25: return 32'h1000004;
      26: return 32'h2000023;
      27: return 32'h4000013;
      28: return 32'h8000004;
      29: return 32'h10000002;
      30: return 32'h20000029;
      31: return 32'h40000004;
      32: return 32'h80000057;
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] galois_next(input logic [31:0] s, input logic [31:0] taps);
    return (s >> 1) ^ (s[0] ? taps : 32'd0);
  endfunction
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational right-shift Galois next state
module lfsr_step
  import prng_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS)
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);
  assign next = WIDTH'(galois_next(32'(state), 32'(TAPS)));
endmodule

// File: rtl/prng_lfsr_gen.sv
// prng_lfsr_gen: Galois LFSR word generator with valid/ready output, seed load and wrap detect
module prng_lfsr_gen
  import prng_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(DEF_SEED),
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [WIDTH-1:0] state_out,
  output logic [WIDTH-1:0] step_cnt,
  output logic             wrap
);
  logic [WIDTH-1:0] state, seed_reg, next, ld;
  logic adv, hit;
  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (.state(state), .next(next));
  assign adv = en & ~seed_load & (~out_valid | out_ready);
  assign hit = next == seed_reg;
  // a zero seed would lock the LFSR, so fall back to SEED
  assign ld = seed_in == '0 ? SEED : seed_in;
  assign out_data = state[OUT_W-1:0];
  assign state_out = state;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEED;
      seed_reg <= SEED;
      out_valid <= 1'b0;
      step_cnt <= '0;
      wrap <= 1'b0;
    end else if (seed_load) begin
      state <= ld;
      seed_reg <= ld;
      out_valid <= 1'b0;
      step_cnt <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= adv & hit;
      if (adv) begin
        state <= next;
        out_valid <= 1'b1;
        step_cnt <= hit ? '0 : step_cnt + WIDTH'(1);
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_prng_lfsr_gen.sv
// tb_prng_lfsr_gen: directed checks plus a per-cycle reference model of the generator
module tb_prng_lfsr_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0, en = 1'b0, seed_load = 1'b0, out_ready = 1'b0;
  logic [15:0] seed_in = '0;
  logic out_valid, wrap;
  logic [7:0] out_data;
  logic [15:0] state_out, step_cnt;
  int passed = 0, total = 0;
  bit chk_on = 1'b0;
  logic [15:0] m_state, m_seed;
  int unsigned m_cnt;
  logic m_valid, m_wrap;
  bit seen [65536];
  int dups, early_wraps;

  prng_lfsr_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .state_out(state_out), .step_cnt(step_cnt), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // reference: polynomial step on the state, cycle count kept as a plain integer
  always @(posedge clk) begin
    automatic logic [15:0] nx = (m_state >> 1) ^ (m_state[0] ? 16'hB400 : 16'h0);
    automatic bit go = en && !seed_load && (!m_valid || out_ready);
    if (!rst_n) begin
      m_state <= 16'hACE1; m_seed <= 16'hACE1; m_valid <= 0; m_cnt <= 0; m_wrap <= 0;
    end else if (seed_load) begin
      m_state <= seed_in == 0 ? 16'hACE1 : seed_in;
      m_seed <= seed_in == 0 ? 16'hACE1 : seed_in;
      m_valid <= 0; m_cnt <= 0; m_wrap <= 0;
    end else begin
      m_wrap <= go && nx == m_seed;
      if (go) begin
        m_state <= nx;
        m_valid <= 1;
        m_cnt <= nx == m_seed ? 0 : (m_cnt + 1) % 65536;
      end else if (m_valid && out_ready) m_valid <= 0;
    end
  end

  always @(negedge clk)
    if (chk_on)
      check("cycle", {22'd0, out_valid, wrap, step_cnt, state_out, out_data},
            {22'd0, m_valid, m_wrap, m_cnt[15:0], m_state, m_state[7:0]});

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input logic [15:0] s, input logic v, input logic [15:0] c);
    check({name, "_state"}, 64'(state_out), 64'(s));
    check({name, "_data"}, 64'(out_data), 64'(s[7:0]));
    check({name, "_valid"}, 64'(out_valid), 64'(v));
    check({name, "_cnt"}, 64'(step_cnt), 64'(c));
  endtask

  initial begin
    tick(); tick();
    chk_on = 1'b1;
    expect_out("reset", 16'hACE1, 0, 0);
    check("reset_wrap", 64'(wrap), 0);
    rst_n = 1; en = 1; out_ready = 1;
    tick(); expect_out("first", 16'hE270, 1, 1);
    tick(); expect_out("second", 16'h7138, 1, 2);
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); expect_out("stall", 16'h7138, 1, 2);
    end
    out_ready = 1;
    tick(); expect_out("release", 16'h389C, 1, 3);
    en = 0;
    tick(); expect_out("drain", 16'h389C, 0, 3);
    tick(); expect_out("idle", 16'h389C, 0, 3);
    seed_load = 1; seed_in = 16'h0000;
    tick(); expect_out("seed_zero", 16'hACE1, 0, 0);
    seed_in = 16'h1234;
    tick(); expect_out("seed_1234", 16'h1234, 0, 0);
    seed_load = 0; en = 1;
    tick(); expect_out("after_seed", 16'h091A, 1, 1);
    seed_load = 1; seed_in = 16'h1234;
    tick(); expect_out("seed_vs_adv", 16'h1234, 0, 0);
    check("seed_vs_adv_wrap", 64'(wrap), 0);
    seed_load = 0;
    for (int i = 0; i < 60; i++) begin
      en = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    en = 1; out_ready = 1; tick(); tick();
    rst_n = 0;
    tick(); expect_out("mid_reset", 16'hACE1, 0, 0);
    rst_n = 1;
    tick(); expect_out("restart1", 16'hE270, 1, 1);
    tick(); expect_out("restart2", 16'h7138, 1, 2);
    rst_n = 0; tick(); rst_n = 1;
    seen[16'hACE1] = 1;
    for (int i = 1; i < 65535; i++) begin
      tick();
      if (seen[state_out]) dups++;
      seen[state_out] = 1;
      if (wrap) early_wraps++;
    end
    check("no_repeat", 64'(dups), 0);
    check("no_early_wrap", 64'(early_wraps), 0);
    tick();
    check("wrap_pulse", 64'(wrap), 1);
    expect_out("wrap", 16'hACE1, 1, 0);
    tick();
    check("wrap_single", 64'(wrap), 0);
    expect_out("post_wrap", 16'hE270, 1, 1);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/prng_lfsr_gen.md
PRNG_LFSR_GEN -- requirements
Module: prng_lfsr_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning LFSR state width (legal 4..32).
REQ-002 The block SHALL have parameter TAPS, default 16'hB400, meaning the Galois feedback mask (maximal-length for WIDTH=16).
REQ-003 The block SHALL have parameter SEED, default 16'hACE1, meaning the reset and fallback seed (nonzero).
REQ-004 The block SHALL have parameter OUT_W, default 8, meaning output word width (1..WIDTH).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit: generation enable.
REQ-008 The block SHALL have port seed_load, input, 1 bit: load seed_in this cycle.
REQ-009 The block SHALL have port seed_in, input, WIDTH bits: seed value.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data holds a fresh, unconsumed word.
REQ-012 The block SHALL have port out_data, output, OUT_W bits: state[OUT_W-1:0].
REQ-013 The block SHALL have port state_out, output, WIDTH bits: full LFSR state.
REQ-014 The block SHALL have port step_cnt, output, WIDTH bits: steps since the last seed or wrap.
REQ-015 The block SHALL have port wrap, output, 1 bit: single-cycle pulse when the state returns to the active seed.

Function
REQ-016 The block SHALL compute the next state as next = (state >> 1) XOR (state[0] ? TAPS : 0), right-shift Galois form.
REQ-017 The block SHALL advance when adv = en AND NOT seed_load AND (NOT out_valid OR out_ready), one step per cycle, no bubbles under continuous ready.
REQ-018 On adv the block SHALL set state <= next and out_valid <= 1, so the new word is visible the following cycle.
REQ-019 If out_valid AND out_ready AND NOT adv, the block SHALL clear out_valid next cycle.
REQ-020 While out_valid=1 and out_ready=0, the block SHALL hold out_data, state_out and step_cnt stable regardless of en.
REQ-021 On seed_load the block SHALL set state and seed_reg to seed_in, or to SEED if seed_in==0 (lock-up guard).
REQ-022 On seed_load the block SHALL clear out_valid and step_cnt and suppress wrap, taking priority over adv and handshake.
REQ-023 On adv the block SHALL increment step_cnt modulo 2^WIDTH.
REQ-024 If next == seed_reg on adv, the block SHALL clear step_cnt instead of incrementing it and assert wrap for exactly the following cycle.
REQ-025 With en=0 and no handshake, the block SHALL keep all state unchanged.
REQ-026 The all-zero state SHALL be unreachable by construction; no other lock-up recovery is required.

Reset
REQ-027 While rst_n=0 at a clk edge, the block SHALL set state=SEED, seed_reg=SEED, out_valid=0, step_cnt=0, wrap=0, overriding every other input.
REQ-028 Reset asserted mid-stream SHALL discard any pending word with no partial handshake, and generation SHALL restart from SEED.

Structure
REQ-029 Shared package prng_pkg SHALL hold the default TAPS/SEED constants, a table of maximal-length Galois masks for widths 4..32, and the next-state function.
REQ-030 A single sub-module lfsr_step (combinational next-state for WIDTH/TAPS) SHALL be instantiated. Handshake, seed, and counter logic SHALL stay in the top level.

Verification
REQ-031 Reset, then en=1, out_ready=1 -> out_data 0x70 (state 0xE270), then 0x38 (state 0x7138), out_valid continuously 1.
REQ-032 Run 65535 steps from SEED -> wrap pulses once at step 65535 with state_out=0xACE1 and step_cnt=0, and no earlier repeat of any state occurs.
REQ-033 Hold out_ready=0 for 5 cycles with en=1 -> out_data, state_out, step_cnt frozen; release -> next word follows with no skipped state.
REQ-034 seed_load with seed_in=0x0000 -> state_out=0xACE1, out_valid=0; with seed_in=0x1234 -> state_out=0x1234, step_cnt=0.
REQ-035 seed_load asserted concurrently with en=1 and out_ready=1 -> seed loads, no advance that cycle, wrap stays 0.
REQ-036 rst_n=0 for one cycle mid-stream -> state_out=0xACE1, out_valid=0, step_cnt=0 next cycle; sequence restarts 0x70, 0x38.
